// File: rtl/norm_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg
// Shared types for the normalizer result serializer.
//   q_t    : one divider quotient, unsigned fixed point, IN_WIDTH bits
//   elem_t : one streamed element after unsigned saturation, OUT_WIDTH bits
//   vec_t  : one captured vector, four elements, index 0 = lane A
//   lane_e : element index within a vector
// Helpers:
//   sat_elem  : clamp a quotient to the element range
//   next_lane : lane sequencing A -> B -> C -> D -> A
// -----------------------------------------------------------------------------
package norm_pkg;

    localparam int DATAWIDTH = 8;
    localparam int IN_WIDTH  = 2 * DATAWIDTH + 2;
    localparam int OUT_WIDTH = 16;
    localparam int NUM_LANES = 4;

    typedef logic [IN_WIDTH-1:0]  q_t;
    typedef logic [OUT_WIDTH-1:0] elem_t;
    typedef elem_t [NUM_LANES-1:0] vec_t;

    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2,
        LANE_D = 2'd3
    } lane_e;

    // Largest quotient that still fits in an element (zero-extended).
    localparam q_t ELEM_MAX = q_t'({OUT_WIDTH{1'b1}});

    // Fractional alignment is unchanged; only the integer part is clamped.
    function automatic elem_t sat_elem(input q_t q);
        if (q > ELEM_MAX) begin
            return '1;
        end
        return q[OUT_WIDTH-1:0];
    endfunction

    function automatic lane_e next_lane(input lane_e l);
        case (l)
            LANE_A:  return LANE_B;
            LANE_B:  return LANE_C;
            LANE_C:  return LANE_D;
            default: return LANE_A;
        endcase
    endfunction

endpackage

// File: rtl/norm_vec_fifo.sv
// -----------------------------------------------------------------------------
// norm_vec_fifo
// Whole-vector FIFO between normalizer capture and the element serializer.
// A push while full is still accepted when a pop happens in the same cycle,
// because the slot being written is the one the head is vacating.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset, empties the FIFO
//   push_i   in   write data_i (ignored when full and not popping)
//   data_i   in   vector to write
//   pop_i    in   retire the head vector (ignored when empty)
//   data_o   out  head vector (meaningful only when !empty_o)
//   full_o   out  all DEPTH slots occupied
//   empty_o  out  no slots occupied
// -----------------------------------------------------------------------------
module norm_vec_fifo
    import norm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  vec_t data_i,
    input  logic pop_i,
    output vec_t data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    vec_t          mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only observed when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/norm_result_serializer.sv
// -----------------------------------------------------------------------------
// norm_result_serializer
// Captures the four normalizer quotients as one vector, saturates each lane,
// buffers whole vectors and streams them out one element per cycle.
// The normalizer cannot be stalled, so full-FIFO vectors are dropped and counted.
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-low reset
//   i_valid_a..d     in   quotient valids from the four dividers
//   i_q_a..d         in   quotient data, unsigned fixed point
//   o_valid          out  element available
//   i_ready          in   sink accepts element
//   o_data           out  saturated element
//   o_lane           out  element index 0=A .. 3=D
//   o_last           out  high with lane D (end of vector)
//   o_drop_cnt       out  dropped vectors, saturating
//   o_overflow       out  sticky: at least one drop
//   o_lane_err       out  sticky: quotient valids disagreed in some cycle
//
// Handshake: an element transfers on a rising edge where o_valid && i_ready.
// While o_valid is high and i_ready low, o_data/o_lane/o_last hold. o_valid
// never drops without a transfer except on reset.
// -----------------------------------------------------------------------------
module norm_result_serializer
    import norm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid_a,
    input  logic                 i_valid_b,
    input  logic                 i_valid_c,
    input  logic                 i_valid_d,
    input  logic [IN_WIDTH-1:0]  i_q_a,
    input  logic [IN_WIDTH-1:0]  i_q_b,
    input  logic [IN_WIDTH-1:0]  i_q_c,
    input  logic [IN_WIDTH-1:0]  i_q_d,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic [1:0]           o_lane,
    output logic                 o_last,
    output logic [CNT_WIDTH-1:0] o_drop_cnt,
    output logic                 o_overflow,
    output logic                 o_lane_err
);

    // ------------------------------------------------------------------
    // Capture and saturation
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0] lane_valid;
    logic                 all_valid;
    logic                 partial_valid;
    vec_t                 cap_vec;

    assign lane_valid    = {i_valid_d, i_valid_c, i_valid_b, i_valid_a};
    assign all_valid     = &lane_valid;
    assign partial_valid = (|lane_valid) && !all_valid;

    always_comb begin
        cap_vec         = '0;
        cap_vec[LANE_A] = sat_elem(i_q_a);
        cap_vec[LANE_B] = sat_elem(i_q_b);
        cap_vec[LANE_C] = sat_elem(i_q_c);
        cap_vec[LANE_D] = sat_elem(i_q_d);
    end

    // ------------------------------------------------------------------
    // Vector FIFO
    // ------------------------------------------------------------------
    vec_t head_vec;
    logic fifo_full;
    logic fifo_empty;
    logic xfer;
    logic pop;
    logic drop;

    norm_vec_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (all_valid),
        .data_i  (cap_vec),
        .pop_i   (pop),
        .data_o  (head_vec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Serializer state: lane index plus status flags
    // ------------------------------------------------------------------
    lane_e                idx_q, idx_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 lane_err_q, lane_err_d;

    assign xfer = !fifo_empty && i_ready;
    // The head vector retires with its last element.
    assign pop  = xfer && (idx_q == LANE_D);
    // A full FIFO only loses the incoming vector if nothing leaves this cycle.
    assign drop = all_valid && fifo_full && !pop;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= LANE_A;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            lane_err_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            lane_err_q <= lane_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        idx_d      = idx_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        lane_err_d = lane_err_q;

        if (xfer) begin
            idx_d = next_lane(idx_q);
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end
        end

        if (partial_valid) begin
            lane_err_d = 1'b1;
        end
    end

    // Output logic: driven only from FIFO storage/pointers and idx flops.
    // Data fields are forced to zero while empty so the bus is clean at rest.
    always_comb begin
        o_valid    = !fifo_empty;
        o_data     = '0;
        o_lane     = 2'd0;
        o_last     = 1'b0;
        if (!fifo_empty) begin
            o_data = head_vec[idx_q];
            o_lane = idx_q;
            o_last = (idx_q == LANE_D);
        end
        o_drop_cnt = drop_cnt_q;
        o_overflow = overflow_q;
        o_lane_err = lane_err_q;
    end

endmodule

// File: tb/tb_norm_result_serializer.sv
module tb_norm_result_serializer;
  import norm_pkg::*;

  localparam int W = 1 + 2 + OUT_WIDTH;  // {last, lane, data}

  // ---------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 i_valid_a, i_valid_b, i_valid_c, i_valid_d;
  logic [IN_WIDTH-1:0]  i_q_a, i_q_b, i_q_c, i_q_d;
  logic                 i_ready;
  logic                 o_valid;
  logic [OUT_WIDTH-1:0] o_data;
  logic [1:0]           o_lane;
  logic                 o_last;
  logic [7:0]           o_drop_cnt;
  logic                 o_overflow;
  logic                 o_lane_err;

  norm_result_serializer #(
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid_a  (i_valid_a),
    .i_valid_b  (i_valid_b),
    .i_valid_c  (i_valid_c),
    .i_valid_d  (i_valid_d),
    .i_q_a      (i_q_a),
    .i_q_b      (i_q_b),
    .i_q_c      (i_q_c),
    .i_q_d      (i_q_d),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_lane     (o_lane),
    .o_last     (o_last),
    .o_drop_cnt (o_drop_cnt),
    .o_overflow (o_overflow),
    .o_lane_err (o_lane_err)
  );

  // ---------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int fail_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [OUT_WIDTH-1:0] sat16(input logic [IN_WIDTH-1:0] q);
    if (q > 18'h0FFFF) return 16'hFFFF;
    return q[OUT_WIDTH-1:0];
  endfunction

  task automatic expect_vec(input logic [IN_WIDTH-1:0] a, b, c, d);
    exp_q.push_back({1'b0, 2'd0, sat16(a)});
    exp_q.push_back({1'b0, 2'd1, sat16(b)});
    exp_q.push_back({1'b0, 2'd2, sat16(c)});
    exp_q.push_back({1'b1, 2'd3, sat16(d)});
  endtask

  // monitor: every transfer pops one expected element
  always @(negedge clk) begin
    if (rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_elem", 32'(exp_q.size()), 1);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("elem", {13'd0, o_last, o_lane, o_data}, 32'(e));
      end
    end
  end

  // ---------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [IN_WIDTH-1:0] a, b, c, d, input bit accept);
    i_q_a = a; i_q_b = b; i_q_c = c; i_q_d = d;
    i_valid_a = 1'b1; i_valid_b = 1'b1; i_valid_c = 1'b1; i_valid_d = 1'b1;
    if (accept) expect_vec(a, b, c, d);
    step();
    i_valid_a = 1'b0; i_valid_b = 1'b0; i_valid_c = 1'b0; i_valid_d = 1'b0;
  endtask

  task automatic push_rand(input bit accept);
    push_vec(18'($urandom_range(0, 18'h3FFFF)), 18'($urandom_range(0, 18'h1FFFF)),
             18'($urandom_range(0, 18'h0FFFF)), 18'($urandom_range(0, 18'h003FF)), accept);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_data"},  o_data,  0);
    check({tag, "_lane"},  o_lane,  0);
    check({tag, "_last"},  o_last,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------
  initial begin
    rst = 1'b0;
    i_ready = 1'b0;
    i_valid_a = 1'b0; i_valid_b = 1'b0; i_valid_c = 1'b0; i_valid_d = 1'b0;
    i_q_a = '0; i_q_b = '0; i_q_c = '0; i_q_d = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    check("rst_drop_cnt", o_drop_cnt, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_lane_err", o_lane_err, 0);
    rst = 1'b1;
    step();
    check("post_rst_valid", o_valid, 0);

    // 1: reset mid-stream discards contents immediately
    push_vec(18'h00011, 18'h00022, 18'h00033, 18'h00044, 1'b1);
    push_vec(18'h00055, 18'h00066, 18'h00077, 18'h00088, 1'b1);
    i_ready = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    i_ready = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release_valid", o_valid, 0);

    // 2: single vector, latency and back-to-back lanes
    i_ready = 1'b1;
    step();
    push_vec(18'h00100, 18'h00080, 18'h00040, 18'h00000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_valid", o_valid, 1);
      check("t2_last", o_last, (i == 3) ? 1 : 0);
    end
    @(negedge clk);
    check("t2_empty_after", o_valid, 0);
    step();

    // 3: saturation
    push_vec(18'h3FFFF, 18'h10000, 18'h0FFFF, 18'h00001, 1'b1);
    drain(20);

    // 4: backpressure, 6 pushes into 4 slots
    i_ready = 1'b0;
    step();
    for (int i = 0; i < 6; i++) push_rand(i < 4);
    check("t4_drop_cnt", o_drop_cnt, 2);
    check("t4_overflow", o_overflow, 1);
    repeat (4) step();
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t4_no_gap", o_valid, 1);
    end
    drain(10);

    // 5: push while full, coincident with lane-D transfer
    i_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) push_rand(1'b1);
    check("t5_full_valid", o_valid, 1);
    i_ready = 1'b1;
    step();
    step();
    step();
    push_rand(1'b1);
    check("t5_drop_cnt_same", o_drop_cnt, 2);
    check("t5_overflow", o_overflow, 1);
    drain(40);

    // 6: lane error on partial valid set
    check("t6_lane_err_before", o_lane_err, 0);
    step();
    i_q_a = 18'h00123; i_q_b = 18'h00456;
    i_valid_a = 1'b1; i_valid_b = 1'b1;
    step();
    i_valid_a = 1'b0; i_valid_b = 1'b0;
    check("t6_lane_err", o_lane_err, 1);
    check("t6_no_push", o_valid, 0);
    repeat (3) step();
    check("t6_lane_err_sticky", o_lane_err, 1);
    check("t6_still_empty", o_valid, 0);

    // random traffic with random backpressure, never overfilling
    for (int i = 0; i < 200; i++) begin
      i_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() <= 12 && $urandom_range(0, 2) == 0) push_rand(1'b1);
      else step();
    end
    drain(200);
    check("rand_drop_cnt", o_drop_cnt, 2);

    // sticky flags clear only on reset
    rst = 1'b0;
    #1;
    check("final_rst_drop_cnt", o_drop_cnt, 0);
    check("final_rst_overflow", o_overflow, 0);
    check("final_rst_lane_err", o_lane_err, 0);
    step();
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
